// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - request/result handshake bundle for the ALU op sequencer
interface alu_op_sequencer_if #(
    parameter int WIDTH = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               carry;
    logic               zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, zero
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - one-at-a-time ALU op sequencer with shift-add multiply
module alu_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_op_sequencer_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [2*WIDTH-1:0] result_q;
    logic               carry_q;
    logic               zero_q;
    logic [CNT_W-1:0]   op_count_q;

    logic [WIDTH:0]     sum_d;
    logic [WIDTH:0]     diff_d;
    logic [WIDTH-1:0]   logic_d;
    logic               exec_carry_d;
    logic [2*WIDTH-1:0] exec_res_d;
    logic [2*WIDTH-1:0] acc_d;

    // Single-cycle results are formed from the latched operands only.
    always_comb begin
        sum_d        = {1'b0, a_q} + {1'b0, b_q};
        diff_d       = {1'b0, a_q} - {1'b0, b_q};
        logic_d      = '0;
        exec_carry_d = 1'b0;
        case (op_q)
            3'b000: logic_d = a_q & b_q;
            3'b001: logic_d = a_q | b_q;
            3'b010: logic_d = a_q ^ b_q;
            3'b011: logic_d = ~(a_q ^ b_q);
            3'b100: begin
                logic_d      = sum_d[WIDTH-1:0];
                exec_carry_d = sum_d[WIDTH];
            end
            3'b101: begin
                logic_d      = diff_d[WIDTH-1:0];
                exec_carry_d = diff_d[WIDTH];
            end
            3'b110: logic_d = ~a_q;
            default: logic_d = '0;
        endcase
        exec_res_d = {{WIDTH{1'b0}}, logic_d};
        acc_d      = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        op_q       <= bus.op;
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        acc_q      <= '0;
                        mcand_q    <= {{WIDTH{1'b0}}, bus.a};
                        mplier_q   <= bus.b;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= (bus.op == 3'b111) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    result_q    <= exec_res_d;
                    carry_q     <= exec_carry_d;
                    zero_q      <= (exec_res_d == '0);
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                MUL: begin
                    // One multiplier bit per cycle; the last iteration registers the product.
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        result_q    <= acc_d;
                        carry_q     <= 1'b0;
                        zero_q      <= (acc_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + CNT_W'(1);
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign busy          = busy_q;
    assign op_count      = op_count_q;
endmodule
